// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation front end.
package me_pkg;

    localparam int MB_SIZE      = 16;
    localparam int PIX_W        = 8;
    localparam int WORDS_PER_MB = 64;
    localparam int MB_PER_FRAME = 8160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/cur_mb_buf.sv
// Current-macroblock pixel store: one 32-bit word write port, one registered row read port.
module cur_mb_buf #(
    parameter int MB_SIZE = me_pkg::MB_SIZE,
    parameter int PIX_W   = me_pkg::PIX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [$clog2(MB_SIZE)-1:0]    wr_row,
    input  logic [$clog2(MB_SIZE*PIX_W/32)-1:0] wr_grp,
    input  logic [31:0]                   wr_data,
    input  logic [$clog2(MB_SIZE)-1:0]    rd_row,
    output logic [MB_SIZE*PIX_W-1:0]      rd_row_data
);

    localparam int PPW   = 32 / PIX_W;
    localparam int COL_W = $clog2(MB_SIZE);

    logic [PIX_W-1:0] mem [MB_SIZE][MB_SIZE];

    // Word write: pixel b of the word lands in column grp*PPW+b (byte0 leftmost).
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < PPW; b++) begin
                mem[wr_row][COL_W'(32'(wr_grp) * PPW + b)] <= wr_data[b*PIX_W +: PIX_W];
            end
        end
    end

    // Registered row readout, pixel c at bits [c*PIX_W +: PIX_W].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_row_data <= '0;
        end else begin
            for (int unsigned c = 0; c < MB_SIZE; c++) begin
                rd_row_data[c*PIX_W +: PIX_W] <= mem[rd_row][COL_W'(c)];
            end
        end
    end

endmodule

// File: rtl/cur_mb_loader.sv
// Fetches one macroblock from the current-frame word stream and holds it for the ME core.
module cur_mb_loader
    import me_pkg::*;
#(
    parameter int MB_SIZE      = me_pkg::MB_SIZE,
    parameter int PIX_W        = me_pkg::PIX_W,
    parameter int MB_PER_FRAME = me_pkg::MB_PER_FRAME
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       release_mb,
    output logic                       read_en,
    input  logic [31:0]                cur_data,
    output logic                       mb_valid,
    output logic [13:0]                mb_idx,
    output logic                       mb_last,
    input  logic [$clog2(MB_SIZE)-1:0] rd_row,
    output logic [MB_SIZE*PIX_W-1:0]   rd_row_data
);

    localparam int PPW   = 32 / PIX_W;
    localparam int GRP_W = $clog2(MB_SIZE / PPW);
    localparam int WORDS = MB_SIZE * MB_SIZE / PPW;
    localparam int WC_W  = $clog2(WORDS);

    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [13:0]     LAST_IDX  = 14'(MB_PER_FRAME - 1);

    state_t            state, next_state;
    logic [WC_W-1:0]   word_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs; read_en also gated directly by pause.
    always_comb begin
        next_state = state;
        read_en    = 1'b0;
        mb_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                read_en = !pause;
                if (read_en && word_cnt == LAST_WORD) next_state = FULL;
            end
            FULL: begin
                mb_valid = 1'b1;
                if (release_mb) next_state = start ? FETCH : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word counter: cleared while idle, steps on each captured word and wraps to 0 after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (state == IDLE) begin
            word_cnt <= '0;
        end else if (read_en) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Macroblock index advances when the held block is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_idx <= '0;
        end else if (state == FULL && release_mb) begin
            mb_idx <= (mb_idx == LAST_IDX) ? '0 : mb_idx + 1'b1;
        end
    end

    assign mb_last = (mb_idx == LAST_IDX);

    cur_mb_buf #(
        .MB_SIZE (MB_SIZE),
        .PIX_W   (PIX_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .we          (read_en),
        .wr_row      (word_cnt[WC_W-1:GRP_W]),
        .wr_grp      (word_cnt[GRP_W-1:0]),
        .wr_data     (cur_data),
        .rd_row      (rd_row),
        .rd_row_data (rd_row_data)
    );

endmodule

// File: tb/tb_cur_mb_loader.sv
// Directed self-checking bench for cur_mb_loader (small-frame and full-frame instances).
module tb_cur_mb_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         pause;
    logic         release_mb;
    logic [3:0]   rd_row;
    logic [31:0]  cur_data;

    logic         read_en, mb_valid, mb_last;
    logic [13:0]  mb_idx;
    logic [127:0] rd_row_data;

    logic         read_en2, mb_valid2, mb_last2;
    logic [13:0]  mb_idx2;
    logic [127:0] rd_row_data2;

    int addr;
    int n_checks = 0;
    int n_errors = 0;
    int ren, vc, bad;

    always #5 clk = ~clk;

    cur_mb_loader #(.MB_PER_FRAME(3)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .release_mb(release_mb),
        .read_en(read_en), .cur_data(cur_data), .mb_valid(mb_valid), .mb_idx(mb_idx),
        .mb_last(mb_last), .rd_row(rd_row), .rd_row_data(rd_row_data)
    );

    cur_mb_loader dut2 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .release_mb(release_mb),
        .read_en(read_en2), .cur_data(cur_data), .mb_valid(mb_valid2), .mb_idx(mb_idx2),
        .mb_last(mb_last2), .rd_row(rd_row), .rd_row_data(rd_row_data2)
    );

    // Stream word w: pixel bytes (4*(w%64)+b), XORed with a per-macroblock key.
    function automatic logic [7:0] mb_key(int m);
        return 8'(m * 8'h5A);
    endfunction

    function automatic logic [31:0] stream_word(int w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = 8'(4 * (w % 64) + b) ^ mb_key(w / 64);
        return r;
    endfunction

    function automatic logic [127:0] exp_row(int r, int m);
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[8*c +: 8] = 8'(16 * r + c) ^ mb_key(m);
        return v;
    endfunction

    // Memory model: address follows read_en and resets with the loader.
    always @(posedge clk or posedge rst) begin
        if (rst) addr <= 0;
        else if (read_en) addr <= addr + 1;
    end

    always_comb cur_data = stream_word(addr);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_row(input int r, input int m, input string tag);
        rd_row = 4'(r);
        @(negedge clk);
        #1;
        check(tag, rd_row_data, exp_row(r, m));
    endtask

    // Walks one load cycle by cycle; cycle 1 is the cycle after the start edge.
    task automatic run_load(input int pause_at, input int pause_len, input bit hold_start,
                            input int stop_at, output int n_ren, output int vcyc, output int n_bad);
        int pcnt = 0;
        n_ren = 0;
        vcyc  = -1;
        n_bad = 0;
        for (int c = 1; c <= 200; c++) begin
            pause = (pause_at >= 0 && n_ren >= pause_at && pcnt < pause_len);
            start = hold_start;
            #1;
            if (mb_valid) begin
                vcyc = c;
                break;
            end
            if (read_en !== !pause) n_bad++;
            if (read_en) n_ren++;
            if (pause) pcnt++;
            if (n_ren == stop_at) break;
            @(negedge clk);
        end
        pause = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; release_mb = 1'b0; rd_row = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_read_en", read_en, 0);
        check("rst_mb_valid", mb_valid, 0);
        check("rst_mb_idx", mb_idx, 0);
        check("rst_mb_last", mb_last, 0);
        check("rst_rd_row_data", rd_row_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // release_mb in IDLE is ignored
        release_mb = 1'b1;
        @(negedge clk);
        release_mb = 1'b0;
        #1;
        check("idle_release_idx", mb_idx, 0);
        check("idle_release_ren", read_en, 0);

        // basic load
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_load(-1, 0, 1'b0, 1000, ren, vc, bad);
        check("basic_ren_cycles", 128'(ren), 64);
        check("basic_valid_cycle", 128'(vc), 65);
        check("basic_ren_shape", 128'(bad), 0);
        read_row(0, 0, "basic_row0");
        read_row(15, 0, "basic_row15");

        // start alone in FULL: stays FULL
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("full_start_valid", mb_valid, 1);
        check("full_start_ren", read_en, 0);

        // release alone: to IDLE, idx 0 -> 1
        release_mb = 1'b1;
        @(negedge clk);
        release_mb = 1'b0;
        #1;
        check("rel_valid", mb_valid, 0);
        check("rel_idx", mb_idx, 1);
        check("rel_last", mb_last, 0);
        check("rel_ren", read_en, 0);
        check("rel_idx_big", mb_idx2, 1);

        // paused load with start held through FETCH
        start = 1'b1;
        @(negedge clk);
        run_load(20, 10, 1'b1, 1000, ren, vc, bad);
        check("pause_ren_cycles", 128'(ren), 64);
        check("pause_valid_cycle", 128'(vc), 75);
        check("pause_ren_shape", 128'(bad), 0);
        read_row(3, 1, "pause_row3");
        read_row(15, 1, "pause_row15");
        check("pause_idx", mb_idx, 1);

        // back-to-back release + start
        release_mb = 1'b1;
        start = 1'b1;
        @(negedge clk);
        release_mb = 1'b0;
        start = 1'b0;
        #1;
        check("b2b_ren", read_en, 1);
        check("b2b_valid", mb_valid, 0);
        check("b2b_idx", mb_idx, 2);
        check("b2b_last", mb_last, 1);
        check("b2b_last_big", mb_last2, 0);
        run_load(-1, 0, 1'b0, 1000, ren, vc, bad);
        check("b2b_ren_cycles", 128'(ren), 64);
        check("b2b_valid_cycle", 128'(vc), 65);
        read_row(7, 2, "b2b_row7");
        check("b2b_last_held", mb_last, 1);

        // wrap from idx 2 to 0, then reset mid-FETCH
        release_mb = 1'b1;
        start = 1'b1;
        @(negedge clk);
        release_mb = 1'b0;
        start = 1'b0;
        #1;
        check("wrap_idx", mb_idx, 0);
        check("wrap_last", mb_last, 0);
        check("wrap_idx_big", mb_idx2, 3);
        check("wrap_ren", read_en, 1);
        run_load(-1, 0, 1'b0, 31, ren, vc, bad);
        check("pre_rst_ren_cycles", 128'(ren), 31);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ren", read_en, 0);
        check("arst_valid", mb_valid, 0);
        check("arst_idx_big", mb_idx2, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_ren", read_en, 0);
        check("post_rst_valid", mb_valid, 0);
        check("post_rst_idx", mb_idx, 0);

        // fresh full load after reset
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_load(-1, 0, 1'b0, 1000, ren, vc, bad);
        check("reload_ren_cycles", 128'(ren), 64);
        check("reload_valid_cycle", 128'(vc), 65);
        read_row(0, 0, "reload_row0");
        read_row(15, 0, "reload_row15");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
